// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_bridge
// SPI mode-0 slave that converts MCU frames into single-cycle register strobes.
// Rev    : 1.0
// ============================================================================

module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int DUMMY_BITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic        r_valid,
    output logic        r_wen,
    output logic [11:0] r_addr,
    output logic [31:0] r_wdata,
    input  logic [31:0] r_rdata
);

    localparam logic [5:0] c_HDR_BITS    = 6'd16;
    localparam logic [5:0] c_WR_BITS     = 6'd48;
    localparam logic [5:0] c_DOUT_START  = 6'(16 + DUMMY_BITS);
    localparam logic [5:0] c_SHIFT_START = 6'(17 + DUMMY_BITS);
    localparam logic [5:0] c_BIT_MAX     = 6'd63;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sclk_prev;
    logic                   r_rise_q;
    logic [5:0]             r_bit_cnt;
    logic [31:0]            r_in_sr;
    logic [31:0]            r_out_sr;

    logic w_sclk;
    logic w_ncs;
    logic w_din;
    logic w_rise;
    logic w_fall;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs  = r_ncs_sync[SYNC_STAGES-1];
    assign w_din  = r_din_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_prev & ~w_ncs;
    assign w_fall = ~w_sclk & r_sclk_prev & ~w_ncs;

    // Chip select resets to the idle (high) level so no frame starts out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_din_sync  <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi_ncs};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], spi_din};
            r_sclk_prev <= w_sclk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise_q  <= 1'b0;
            r_bit_cnt <= '0;
            r_in_sr   <= '0;
        end else begin
            r_rise_q <= w_rise;
            if (w_ncs) begin
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_in_sr <= {r_in_sr[30:0], w_din};
                if (r_bit_cnt != c_BIT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
            end
        end
    end

    // Decisions are taken the clk after the counting edge, so the counter value
    // uniquely identifies the 16th / 48th bit and fires once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_out_sr <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_rise_q && !w_ncs && r_bit_cnt == c_HDR_BITS) begin
                r_addr <= r_in_sr[11:0];
                r_wen  <= r_in_sr[15];
                if (!r_in_sr[15]) begin
                    r_valid <= 1'b1;
                end
            end
            if (r_rise_q && !w_ncs && r_wen && r_bit_cnt == c_WR_BITS) begin
                r_wdata <= r_in_sr;
                r_valid <= 1'b1;
            end
            if (r_valid && !r_wen) begin
                r_out_sr <= r_rdata;
            end else if (w_fall && r_bit_cnt >= c_SHIFT_START) begin
                r_out_sr <= {r_out_sr[30:0], 1'b0};
            end
        end
    end

    // Driven straight from flops to keep MISO latency within one SPI half period.
    assign spi_dout = ~w_ncs & ~r_wen & (r_bit_cnt >= c_DOUT_START) & r_out_sr[31];

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_reg_bridge
// Directed and randomized SPI frames checked against a frame-level model.
// Rev    : 1.0
// ============================================================================

module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        spi_ncs;
    logic        spi_din;
    logic        spi_dout;
    logic        r_valid;
    logic        r_wen;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] rdata_val;

    int checks = 0;
    int errors = 0;

    logic [44:0] stb_q[$];

    logic        m_wen;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;

    assign r_rdata = rdata_val;

    spi_reg_bridge #(.SYNC_STAGES(2), .DUMMY_BITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .spi_ncs  (spi_ncs),
        .spi_din  (spi_din),
        .spi_dout (spi_dout),
        .r_valid  (r_valid),
        .r_wen    (r_wen),
        .r_addr   (r_addr),
        .r_wdata  (r_wdata),
        .r_rdata  (r_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_valid) stb_q.push_back({r_wen, r_addr, r_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MCU side: clk/8 SPI, MISO sampled just before each rising edge.
    task automatic spi_send(input logic [63:0] bits, input int n,
                            output logic [31:0] miso, output logic early_nz,
                            output logic any_nz);
        miso = '0;
        early_nz = 1'b0;
        any_nz = 1'b0;
        @(posedge clk); #1;
        spi_ncs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 1; i <= n; i++) begin
            spi_din = bits[64-i];
            repeat (4) @(posedge clk);
            #1;
            if (spi_dout !== 1'b0) begin
                any_nz = 1'b1;
                if (i <= 24) early_nz = 1'b1;
            end
            if (i >= 25 && i <= 56) miso = {miso[30:0], spi_dout};
            spi_clk = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            spi_clk = 1'b0;
        end
        repeat (8) @(posedge clk);
        #1;
        spi_ncs = 1'b1;
        spi_din = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [63:0] bits, input int n,
                             input logic [31:0] rd);
        logic [31:0] miso;
        logic        early_nz;
        logic        any_nz;
        logic [15:0] hdr;
        logic        wr;
        int          exp_n;
        rdata_val = rd;
        stb_q.delete();
        spi_send(bits, n, miso, early_nz, any_nz);
        hdr = bits[63:48];
        wr  = hdr[15];
        if (n >= 16) begin
            m_addr = hdr[11:0];
            m_wen  = wr;
        end
        if (wr && n >= 48) m_wdata = bits[47:16];
        exp_n = ((!wr && n >= 16) || (wr && n >= 48)) ? 1 : 0;
        check({tag, "_nstb"}, 64'(stb_q.size()), 64'(exp_n));
        if (exp_n == 1 && stb_q.size() == 1)
            check({tag, "_stb"}, {19'd0, stb_q[0]}, {19'd0, m_wen, m_addr, m_wdata});
        check({tag, "_wen"}, {63'd0, r_wen}, {63'd0, m_wen});
        check({tag, "_addr"}, {52'd0, r_addr}, {52'd0, m_addr});
        check({tag, "_wdata"}, {32'd0, r_wdata}, {32'd0, m_wdata});
        check({tag, "_vld_idle"}, {63'd0, r_valid}, 64'd0);
        if (wr) check({tag, "_dout_wr"}, {63'd0, any_nz}, 64'd0);
        else    check({tag, "_dout_early"}, {63'd0, early_nz}, 64'd0);
        if (!wr && n >= 56) check({tag, "_miso"}, {32'd0, miso}, {32'd0, rd});
        check({tag, "_dout_idle"}, {63'd0, spi_dout}, 64'd0);
    endtask

    initial begin
        logic [15:0] hdr;
        logic [31:0] dat;
        int          n;

        reset     = 1'b1;
        spi_clk   = 1'b0;
        spi_ncs   = 1'b1;
        spi_din   = 1'b0;
        rdata_val = '0;
        m_wen     = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, r_valid}, 64'd0);
        check("rst_wen", {63'd0, r_wen}, 64'd0);
        check("rst_addr", {52'd0, r_addr}, 64'd0);
        check("rst_wdata", {32'd0, r_wdata}, 64'd0);
        check("rst_dout", {63'd0, spi_dout}, 64'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        run_frame("wr123", {16'h8123, 32'hDEADBEEF, 16'h0}, 48, 32'h0);

        // Asynchronous reset mid-cycle must clear outputs before the next edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_wen", {63'd0, r_wen}, 64'd0);
        check("arst_addr", {52'd0, r_addr}, 64'd0);
        check("arst_wdata", {32'd0, r_wdata}, 64'd0);
        m_wen = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stb_q.delete();
        repeat (50) @(posedge clk);
        #1;
        check("arst_nostb", 64'(stb_q.size()), 64'd0);

        run_frame("rd040", {16'h0040, 48'h0}, 56, 32'h12345678);
        run_frame("wr_abort", {16'h8555, 32'hCAFEF00D, 16'h0}, 30, 32'h0);
        run_frame("wr001", {16'h8001, 32'h0000000F, 16'h0}, 48, 32'h0);
        run_frame("wrFFF", {16'h8FFF, 32'hA5A5A5A5, 16'h0}, 56, 32'h0);
        run_frame("rd7FF", {16'h07FF, 48'h0}, 64, 32'h9ABCDEF0);
        run_frame("wrF001", {16'hF001, 32'h13579BDF, 16'h0}, 48, 32'h0);

        for (int k = 0; k < 8; k++) begin
            hdr = 16'($urandom);
            dat = $urandom;
            n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 47))
                                              : int'($urandom_range(48, 64));
            run_frame($sformatf("rnd%0d", k), {hdr, dat, 16'($urandom)}, n, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
